pll_reset_seq: RTL and testbench
================================

// Module: pll_reset_seq
// PURPOSE
//   Supervises the 7-output system PLL and sequences core resets. Runs on the free-running
//   50 MHz board clock; consumes the PLL's asynchronous locked flag and produces the PLL
//   reset and NUM_STAGES staged reset releases (video/SDRAM first, CPU last), plus a ready flag.
//   Consumers in PLL-derived domains re-synchronise rst_out locally (assert async, release sync).
// PARAMETERS
//   NUM_STAGES      4      number of staged reset outputs (1..8)
//   SYNC_STAGES     2      flip-flops in locked synchroniser (>=2)
//   PLL_RST_CYCLES  64     clk cycles pll_rst is held high per PLL reset pulse (>=1)
//   LOCK_TIMEOUT    1<<20  clk cycles to wait for lock before re-pulsing pll_rst (>=1)
//   LOCK_STABLE     4096   consecutive locked cycles required before first release (>=1)
//   STAGE_GAP       256    clk cycles between successive stage releases (>=1)
// PORTS
//   clk             in   1           50 MHz free-running reference clock (not a PLL output)
//   rst             in   1           synchronous, active-high reset
//   pll_locked      in   1           PLL locked, asynchronous to clk
//   pll_rst         out  1           reset to PLL, registered
//   rst_out         out  NUM_STAGES  staged resets, active-high; bit 0 released first
//   ready           out  1           all stages released and lock held
//   unlock_count    out  8           saturating count of lock losses after STABLE completed
// BEHAVIOUR
//   Reset: one clk cycle; on clk edge with rst=1 -> state PLLRST, pll_rst=1, rst_out=all 1,
//     ready=0, unlock_count=0, counters=0, synchroniser flops=0. Holding rst keeps these values.
//   locked_s = pll_locked after SYNC_STAGES flops; all decisions use locked_s only.
//   One counter cnt, cleared on every state change. States:
//   PLLRST   pll_rst=1; after PLL_RST_CYCLES cycles -> WAITLOCK.
//   WAITLOCK pll_rst=0; locked_s=1 -> STABLE; cnt reaches LOCK_TIMEOUT with locked_s=0 -> PLLRST.
//   STABLE   locked_s=0 -> WAITLOCK (cnt cleared, no unlock_count increment);
//            LOCK_STABLE consecutive locked_s=1 cycles -> REL with stage index k=0.
//   REL      rst_out[k] deasserts on entry cycle; after STAGE_GAP cycles k++ and next bit deasserts;
//            when bit NUM_STAGES-1 deasserts -> RUN on the same edge.
//   RUN      ready=1 registered on entry edge; stays until lock loss or rst.
//   Lock loss in REL or RUN (locked_s=0): same edge -> rst_out=all 1, ready=0, state WAITLOCK,
//     unlock_count+1 saturating at 255; pll_rst not pulsed unless WAITLOCK then times out.
//   Release order strictly bit 0..N-1, never two bits on the same edge; reassertion is all at once.
//   rst_out bits are monotonic during REL: released bits never re-assert except on lock loss/rst.
//   rst has priority over every state transition and over lock loss on the same edge.
//   pll_locked glitch shorter than one clk period may be missed; any sampled low counts as loss.
//   All outputs registered; no combinational path from inputs to outputs.
// TESTING (params: SYNC=2, PLL_RST=4, TIMEOUT=50, STABLE=10, GAP=5, N=4)
//   rst 1 cycle, locked high from t=0 -> pll_rst high 4 cycles; rst_out 1111->1110->1100->1000
//     ->0000 at 5-cycle spacing; ready=1 with last release; unlock_count=0.
//   locked never rises -> pll_rst re-pulses 4 cycles every 54 cycles; rst_out stays 1111.
//   locked drops for 3 cycles inside STABLE at count 7 -> counting restarts, first release
//     exactly 10 locked_s cycles after recovery; unlock_count=0.
//   locked drops in RUN -> 2 cycles later (sync) rst_out=1111, ready=0, unlock_count=1;
//     relock -> full sequence repeats, no pll_rst pulse.
//   rst asserted mid-REL with rst_out=1100 -> next edge rst_out=1111, pll_rst=1, count=0.
//   256 lock losses in RUN -> unlock_count saturates at 255, no wrap.

Source files
------------

// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: PLL lock/reset and staged reset bundle (master drives pll_rst, rst_out, ready, unlock_count; slave drives pll_locked)
interface pll_reset_seq_if #(
  parameter int NUM_STAGES = 4
);
  logic                  pll_locked;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic [7:0]            unlock_count;
  modport master (input pll_locked, output pll_rst, rst_out, ready, unlock_count);
  modport slave (output pll_locked, input pll_rst, rst_out, ready, unlock_count);
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulsing, lock supervision and staged reset release (clk, rst in; bus: pll_locked in, pll_rst/rst_out/ready/unlock_count out)
module pll_reset_seq #(
  parameter int NUM_STAGES     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 64,
  parameter int LOCK_TIMEOUT   = 1 << 20,
  parameter int LOCK_STABLE    = 4096,
  parameter int STAGE_GAP      = 256
) (
  input logic clk,
  input logic rst,
  pll_reset_seq_if.master bus
);
  localparam int MAXC = PLL_RST_CYCLES > LOCK_TIMEOUT ?
                        (PLL_RST_CYCLES > LOCK_STABLE ? (PLL_RST_CYCLES > STAGE_GAP ? PLL_RST_CYCLES : STAGE_GAP)
                                                      : (LOCK_STABLE > STAGE_GAP ? LOCK_STABLE : STAGE_GAP))
                      : (LOCK_TIMEOUT > LOCK_STABLE ? (LOCK_TIMEOUT > STAGE_GAP ? LOCK_TIMEOUT : STAGE_GAP)
                                                    : (LOCK_STABLE > STAGE_GAP ? LOCK_STABLE : STAGE_GAP));
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [NUM_STAGES-1:0] LAST = NUM_STAGES'(1) << (NUM_STAGES - 1);
  typedef enum logic [2:0] {PLLRST, WAITLOCK, STABLE, REL, RUN} state_t;
  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   locked_s, rel, last, lost;
  assign locked_s = sync[SYNC_STAGES-1];
  assign last = bus.rst_out == LAST;
  always_comb begin
    rel = locked_s && ((state == STABLE && cnt == CW'(LOCK_STABLE - 1)) ||
                       (state == REL && cnt == CW'(STAGE_GAP - 1)));
    lost = (state == REL || state == RUN) && !locked_s;
    state_n = state == PLLRST   ? (cnt == CW'(PLL_RST_CYCLES - 1) ? WAITLOCK : PLLRST)
            : state == WAITLOCK ? (locked_s ? STABLE : cnt == CW'(LOCK_TIMEOUT - 1) ? PLLRST : WAITLOCK)
            : !locked_s         ? WAITLOCK
            : rel               ? (last ? RUN : REL)
            : state;
    cnt_n = (state_n != state || rel) ? '0 : state == RUN ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= PLLRST;
      cnt              <= '0;
      sync             <= '0;
      bus.pll_rst      <= 1'b1;
      bus.rst_out      <= '1;
      bus.ready        <= 1'b0;
      bus.unlock_count <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sync        <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
      bus.pll_rst <= state_n == PLLRST;
      bus.ready   <= state_n == RUN;
      bus.rst_out <= (state_n == PLLRST || state_n == WAITLOCK || state_n == STABLE) ? '1
                   : rel ? bus.rst_out << 1 : bus.rst_out;
      if (lost && bus.unlock_count != 8'hff) bus.unlock_count <= bus.unlock_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: table, directed and random checks of pll_reset_seq against a lock-run-length reference model
module tb_pll_reset_seq;
  localparam int N = 4, P = 4, T = 50, S = 10, G = 5, SY = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pll_reset_seq_if #(.NUM_STAGES(N)) bus ();
  pll_reset_seq #(
    .NUM_STAGES(N), .SYNC_STAGES(SY), .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT(T), .LOCK_STABLE(S), .STAGE_GAP(G)
  ) dut (.clk(clk), .rst(rst), .bus(bus.master));
  int n_chk = 0, n_pass = 0;
  int pulse_left, wait_n, lk, uc_m;
  bit q[$];
  typedef struct {
    bit         r;
    bit         l;
    int         n;
    bit         e_pll;
    logic [N-1:0] e_ro;
    bit         e_rdy;
    int         e_uc;
  } vec_t;
  vec_t tbl[15];
  function automatic int released();
    int r;
    r = lk > S ? 1 + (lk - S - 1) / G : 0;
    return r > N ? N : r;
  endfunction
  function automatic logic [31:0] model_vec();
    logic [N-1:0] ro;
    ro = N'(~((1 << released()) - 1));
    return {18'b0, pulse_left > 0, ro, released() == N, 8'(uc_m)};
  endfunction
  function automatic logic [31:0] dut_vec();
    return {18'b0, bus.pll_rst, bus.rst_out, bus.ready, bus.unlock_count};
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  task automatic model_step(input bit r, input bit l);
    bit ls;
    if (r) begin
      pulse_left = P;
      wait_n = 0;
      lk = 0;
      uc_m = 0;
      q = {};
      repeat (SY) q.push_back(1'b0);
    end else begin
      ls = q.pop_front();
      q.push_back(l);
      if (pulse_left > 0) pulse_left--;
      else if (lk == 0) begin
        if (ls) lk = 1;
        else begin
          wait_n++;
          if (wait_n == T) begin
            pulse_left = P;
            wait_n = 0;
          end
        end
      end else if (!ls) begin
        if (released() > 0) uc_m = uc_m == 255 ? 255 : uc_m + 1;
        lk = 0;
        wait_n = 0;
      end else lk++;
    end
  endtask
  task automatic tick(input bit r, input bit l);
    rst = r;
    bus.pll_locked = l;
    @(posedge clk);
    model_step(r, l);
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask
  initial begin
    bit found;
    bit l;
    int len, done;
    tbl[0]  = '{1, 1, 1,  1, 4'hF, 0, 0};
    tbl[1]  = '{0, 1, 3,  1, 4'hF, 0, 0};
    tbl[2]  = '{0, 1, 1,  0, 4'hF, 0, 0};
    tbl[3]  = '{0, 1, 11, 0, 4'hE, 0, 0};
    tbl[4]  = '{0, 1, 4,  0, 4'hE, 0, 0};
    tbl[5]  = '{0, 1, 1,  0, 4'hC, 0, 0};
    tbl[6]  = '{0, 1, 5,  0, 4'h8, 0, 0};
    tbl[7]  = '{0, 1, 4,  0, 4'h8, 0, 0};
    tbl[8]  = '{0, 1, 1,  0, 4'h0, 1, 0};
    tbl[9]  = '{0, 1, 20, 0, 4'h0, 1, 0};
    tbl[10] = '{0, 0, 2,  0, 4'h0, 1, 0};
    tbl[11] = '{0, 0, 1,  0, 4'hF, 0, 1};
    tbl[12] = '{0, 1, 12, 0, 4'hF, 0, 1};
    tbl[13] = '{0, 1, 1,  0, 4'hE, 0, 1};
    tbl[14] = '{0, 1, 15, 0, 4'h0, 1, 1};
    bus.pll_locked = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].n) tick(tbl[i].r, tbl[i].l);
      check($sformatf("tbl%0d", i), dut_vec(),
            {18'b0, tbl[i].e_pll, tbl[i].e_ro, tbl[i].e_rdy, 8'(tbl[i].e_uc)});
    end
    repeat (3) tick(0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(0, 1);
      found = bus.rst_out == 4'hC;
    end
    check("wait_1100", 32'(bus.rst_out), 32'hC);
    check("uc_before_rst", 32'(bus.unlock_count), 32'd2);
    tick(1, 1);
    check("rst_mid_rel", dut_vec(), {18'b0, 1'b1, 4'hF, 1'b0, 8'd0});
    tick(1, 0);
    repeat (53) tick(0, 0);
    check("nolock_e53", 32'(bus.pll_rst), 32'd0);
    tick(0, 0);
    check("nolock_e54", 32'(bus.pll_rst), 32'd1);
    repeat (3) tick(0, 0);
    check("nolock_e57", 32'(bus.pll_rst), 32'd1);
    tick(0, 0);
    check("nolock_e58", 32'(bus.pll_rst), 32'd0);
    repeat (50) tick(0, 0);
    check("nolock_e108", {27'b0, bus.pll_rst, bus.rst_out}, {27'b0, 1'b1, 4'hF});
    tick(1, 1);
    repeat (10) tick(0, 1);
    repeat (3) tick(0, 0);
    repeat (12) tick(0, 1);
    check("stable_drop_e25", 32'(bus.rst_out), 32'hF);
    tick(0, 1);
    check("stable_drop_e26", {23'b0, bus.rst_out, bus.unlock_count}, {23'b0, 4'hE, 8'd0});
    tick(1, 1);
    repeat (40) tick(0, 1);
    for (int i = 0; i < 256; i++) begin
      repeat (3) tick(0, 0);
      repeat (35) tick(0, 1);
      if (i == 254) check("sat_255", 32'(bus.unlock_count), 32'd255);
    end
    check("sat_hold", {23'b0, bus.ready, bus.unlock_count}, {23'b0, 1'b1, 8'd255});
    tick(1, 1);
    done = 0;
    while (done < 3000) begin
      l = 1'($urandom_range(0, 1));
      len = l ? $urandom_range(1, 40) : ($urandom_range(0, 7) == 0 ? $urandom_range(50, 120) : $urandom_range(1, 6));
      if ($urandom_range(0, 30) == 0) begin
        tick(1, l);
        done++;
      end
      repeat (len) tick(0, l);
      done += len;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
